// File: rtl/dmem_pkg.sv
// Shared encodings, arbiter states, request payload type and the alignment
// check used by the data-memory arbiter.
package dmem_pkg;

   // Load size encodings as understood by dmem RSel
   localparam logic [2:0] RSEL_W  = 3'd0;
   localparam logic [2:0] RSEL_H  = 3'd1;
   localparam logic [2:0] RSEL_B  = 3'd2;
   localparam logic [2:0] RSEL_HU = 3'd3;
   localparam logic [2:0] RSEL_BU = 3'd4;

   // Store size encodings as understood by dmem WSel
   localparam logic [1:0] WSEL_W  = 2'd0;
   localparam logic [1:0] WSEL_H  = 2'd1;
   localparam logic [1:0] WSEL_B  = 2'd2;

   // Arbiter states
   localparam logic [1:0] ST_ARB   = 2'd0;
   localparam logic [1:0] ST_LOCK  = 2'd1;
   localparam logic [1:0] ST_FORCE = 2'd2;

   // One requester's access description
   typedef struct packed {
      logic        we;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [2:0]  rsel;
      logic [1:0]  wsel;
   } req_payload_t;

   // Word accesses need addr[1:0]==0, halfword accesses need addr[0]==0;
   // byte accesses are always aligned.
   function automatic logic misaligned(input logic       we,
                                       input logic [2:0] rsel,
                                       input logic [1:0] wsel,
                                       input logic [1:0] a);
      logic m;
      m = 1'b0;
      if (we) begin
         if (wsel == WSEL_W)
            m = (a != 2'b00);
         else if (wsel == WSEL_H)
            m = a[0];
      end else begin
         if (rsel == RSEL_W)
            m = (a != 2'b00);
         else if ((rsel == RSEL_H) || (rsel == RSEL_HU))
            m = a[0];
      end
      return m;
   endfunction

endpackage

// File: rtl/dmem_rr_arb2.sv
// Two-way round-robin arbiter. An enabled priority override hands the grant
// to prio_port whenever that port requests; otherwise a tie goes to the port
// that did not win last time.
module dmem_rr_arb2 (
   input  logic [1:0] req,
   input  logic       last_winner,
   input  logic       prio_en,
   input  logic       prio_port,
   output logic [1:0] gnt
);

   // One-hot (or zero) grant selection
   always_comb begin
      gnt = 2'b00;
      if (prio_en && req[prio_port]) begin
         gnt = prio_port ? 2'b10 : 2'b01;
      end else if (req == 2'b11) begin
         gnt = last_winner ? 2'b01 : 2'b10;
      end else begin
         gnt = req;
      end
   end

endmodule

// File: rtl/dmem_arbiter.sv
// Shares the single-port data memory between the CPU load/store unit (port 0)
// and the DMA/debug loader (port 1). One access per cycle, read data returned
// one cycle after grant, bounded bus lock for port 1, misaligned accesses
// answered with an error instead of being issued.
module dmem_arbiter
   import dmem_pkg::*;
#(
   parameter int MAX_LOCK = 16,
   parameter int CNT_W    = 5
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        p0_req,
   input  logic        p0_we,
   input  logic [31:0] p0_addr,
   input  logic [31:0] p0_wdata,
   input  logic [2:0]  p0_rsel,
   input  logic [1:0]  p0_wsel,
   output logic        p0_gnt,
   output logic        p0_rvalid,
   output logic        p0_err,
   input  logic        p1_req,
   input  logic        p1_we,
   input  logic [31:0] p1_addr,
   input  logic [31:0] p1_wdata,
   input  logic [2:0]  p1_rsel,
   input  logic [1:0]  p1_wsel,
   input  logic        p1_lock,
   output logic        p1_gnt,
   output logic        p1_rvalid,
   output logic        p1_err,
   output logic [31:0] rdata,
   output logic [31:0] mem_addr,
   output logic [31:0] mem_dataw,
   output logic        mem_wen,
   output logic [2:0]  mem_rsel,
   output logic [1:0]  mem_wsel,
   input  logic [31:0] mem_datar
);

   req_payload_t     pl [2];
   req_payload_t     win_pl;
   logic [1:0]       req;
   logic [1:0]       gnt;
   logic [1:0]       mis;
   logic [1:0]       state_reg, state_next;
   logic [CNT_W-1:0] lock_cnt_reg, lock_cnt_next, cnt_inc;
   logic             last_winner_reg;
   logic             lock_hold;
   logic             prio_en, prio_port;
   logic             win;
   logic [1:0]       rvalid_reg, err_reg;

   assign req   = {p1_req, p0_req};
   assign pl[0] = '{we: p0_we, addr: p0_addr, wdata: p0_wdata, rsel: p0_rsel, wsel: p0_wsel};
   assign pl[1] = '{we: p1_we, addr: p1_addr, wdata: p1_wdata, rsel: p1_rsel, wsel: p1_wsel};

   genvar gi;
   generate
      for (gi = 0; gi < 2; gi++) begin : g_port
         assign mis[gi] = misaligned(pl[gi].we, pl[gi].rsel, pl[gi].wsel, pl[gi].addr[1:0]);
      end
   endgenerate

   // Port 1 keeps the bus while locked; the forced-release cycle favours port 0
   assign lock_hold = (state_reg == ST_LOCK) && p1_req && p1_lock;
   assign prio_en   = lock_hold || (state_reg == ST_FORCE);
   assign prio_port = (state_reg != ST_FORCE);

   dmem_rr_arb2 u_rr (
      .req         (req),
      .last_winner (last_winner_reg),
      .prio_en     (prio_en),
      .prio_port   (prio_port),
      .gnt         (gnt)
   );

   assign cnt_inc = lock_cnt_reg + CNT_W'(1);

   // Lock FSM: entry on a locked port 1 grant, count locked grants, force release at MAX_LOCK
   always_comb begin
      state_next    = ST_ARB;
      lock_cnt_next = '0;
      if (state_reg == ST_FORCE) begin
         state_next    = ST_ARB;
         lock_cnt_next = '0;
      end else if (lock_hold) begin
         lock_cnt_next = cnt_inc;
         state_next    = (cnt_inc == CNT_W'(MAX_LOCK)) ? ST_FORCE : ST_LOCK;
      end else if (gnt[1] && p1_lock) begin
         lock_cnt_next = CNT_W'(1);
         state_next    = (CNT_W'(1) == CNT_W'(MAX_LOCK)) ? ST_FORCE : ST_LOCK;
      end
   end

   assign win    = gnt[1];
   assign win_pl = pl[win];

   // Steer the winner's payload to the memory; idle bus drives zeros
   always_comb begin
      mem_addr  = '0;
      mem_dataw = '0;
      mem_wen   = 1'b0;
      mem_rsel  = '0;
      mem_wsel  = '0;
      if (|gnt) begin
         mem_addr  = win_pl.addr;
         mem_dataw = win_pl.wdata;
         mem_wen   = win_pl.we & ~mis[win];
         mem_rsel  = win_pl.rsel;
         mem_wsel  = win_pl.wsel;
      end
   end

   // State, round-robin history and the one-deep rvalid/err pipeline
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_reg       <= ST_ARB;
         lock_cnt_reg    <= '0;
         last_winner_reg <= 1'b1;
         rvalid_reg      <= '0;
         err_reg         <= '0;
      end else begin
         state_reg    <= state_next;
         lock_cnt_reg <= lock_cnt_next;
         if (|gnt)
            last_winner_reg <= gnt[1];
         for (int i = 0; i < 2; i++) begin
            rvalid_reg[i] <= gnt[i] & (~pl[i].we | mis[i]);
            err_reg[i]    <= gnt[i] & mis[i];
         end
      end
   end

   assign p0_gnt    = gnt[0];
   assign p1_gnt    = gnt[1];
   assign p0_rvalid = rvalid_reg[0];
   assign p1_rvalid = rvalid_reg[1];
   assign p0_err    = err_reg[0];
   assign p1_err    = err_reg[1];
   assign rdata     = mem_datar;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: directed scenarios followed by randomized traffic,
// checked against a transaction-level model with its own shadow memory.
module tb_dmem_arbiter;
   import dmem_pkg::*;

   localparam int MAX_LOCK = 16;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        p0_req, p0_we, p1_req, p1_we, p1_lock;
   logic [31:0] p0_addr, p0_wdata, p1_addr, p1_wdata;
   logic [2:0]  p0_rsel, p1_rsel;
   logic [1:0]  p0_wsel, p1_wsel;
   logic        p0_gnt, p0_rvalid, p0_err, p1_gnt, p1_rvalid, p1_err;
   logic [31:0] rdata, mem_addr, mem_dataw, mem_datar;
   logic        mem_wen;
   logic [2:0]  mem_rsel;
   logic [1:0]  mem_wsel;

   int n_vec = 0;
   int n_bad = 0;
   bit chk_en = 1'b0;

   // model state
   logic [31:0] shadow [256];
   int          m_last, m_run, m_win;
   bit          m_locked, m_force;
   bit [1:0]    pv, perr;
   bit          pchk;
   logic [31:0] prdata;
   logic        got_p0, got_p1, got_wen;

   dmem_arbiter #(.MAX_LOCK(MAX_LOCK), .CNT_W(5)) dut (
      .clk(clk), .rst_n(rst_n),
      .p0_req(p0_req), .p0_we(p0_we), .p0_addr(p0_addr), .p0_wdata(p0_wdata),
      .p0_rsel(p0_rsel), .p0_wsel(p0_wsel), .p0_gnt(p0_gnt), .p0_rvalid(p0_rvalid), .p0_err(p0_err),
      .p1_req(p1_req), .p1_we(p1_we), .p1_addr(p1_addr), .p1_wdata(p1_wdata),
      .p1_rsel(p1_rsel), .p1_wsel(p1_wsel), .p1_lock(p1_lock),
      .p1_gnt(p1_gnt), .p1_rvalid(p1_rvalid), .p1_err(p1_err),
      .rdata(rdata), .mem_addr(mem_addr), .mem_dataw(mem_dataw), .mem_wen(mem_wen),
      .mem_rsel(mem_rsel), .mem_wsel(mem_wsel), .mem_datar(mem_datar)
   );

   always #5 clk = ~clk;

   function automatic logic [31:0] init_word(input int i);
      return 32'(i) * 32'h9E3779B1 ^ 32'h0F0F1234;
   endfunction

   // dmem read formatting: select lane, then sign or zero extend
   function automatic logic [31:0] ld_fmt(input logic [31:0] w, input logic [1:0] a, input logic [2:0] rs);
      logic [15:0] h;
      logic [7:0]  b;
      h = a[1] ? w[31:16] : w[15:0];
      b = 8'(w >> {a, 3'b000});
      case (rs)
         RSEL_H:  return {{16{h[15]}}, h};
         RSEL_B:  return {{24{b[7]}}, b};
         RSEL_HU: return {16'h0, h};
         RSEL_BU: return {24'h0, b};
         default: return w;
      endcase
   endfunction

   function automatic logic [31:0] st_merge(input logic [31:0] w, input logic [1:0] a,
                                            input logic [1:0] ws, input logic [31:0] d);
      logic [31:0] r;
      r = w;
      case (ws)
         WSEL_W: r = d;
         WSEL_H: if (a[1]) r[31:16] = d[15:0]; else r[15:0] = d[15:0];
         default: r[{a, 3'b000} +: 8] = d[7:0];
      endcase
      return r;
   endfunction

   // alignment rule: address must be a multiple of the access size in bytes
   function automatic bit mis_model(input logic we, input logic [2:0] rs, input logic [1:0] ws,
                                    input logic [31:0] a);
      int size;
      if (we) size = (ws == WSEL_W) ? 4 : (ws == WSEL_H) ? 2 : 1;
      else    size = (rs == RSEL_W) ? 4 : ((rs == RSEL_H) || (rs == RSEL_HU)) ? 2 : 1;
      return (int'(a[1:0]) % size) != 0;
   endfunction

   // behavioural dmem: write at edge, read data registered one cycle
   logic [31:0] dmem [256];
   logic        mem_init_done = 1'b0;
   always @(posedge clk) begin
      if (!mem_init_done) begin
         for (int i = 0; i < 256; i++) dmem[i] <= init_word(i);
         mem_init_done <= 1'b1;
      end else begin
         if (mem_wen)
            dmem[mem_addr[9:2]] <= st_merge(dmem[mem_addr[9:2]], mem_addr[1:0], mem_wsel, mem_dataw);
         mem_datar <= ld_fmt(dmem[mem_addr[9:2]], mem_addr[1:0], mem_rsel);
      end
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      assert (got === exp) else begin
         n_bad++;
         $error("FAIL %s: observed %h expected %h", tag, got, exp);
      end
   endtask

   task automatic set_p0(input logic r, input logic we, input logic [31:0] a, input logic [31:0] d,
                         input logic [2:0] rs, input logic [1:0] ws);
      p0_req = r; p0_we = we; p0_addr = a; p0_wdata = d; p0_rsel = rs; p0_wsel = ws;
   endtask

   task automatic set_p1(input logic r, input logic we, input logic [31:0] a, input logic [31:0] d,
                         input logic [2:0] rs, input logic [1:0] ws, input logic lk);
      p1_req = r; p1_we = we; p1_addr = a; p1_wdata = d; p1_rsel = rs; p1_wsel = ws; p1_lock = lk;
   endtask

   // One clock cycle: check outputs against the model, then advance model and clock
   task automatic tick();
      int          win;
      logic        we;
      logic [31:0] a, d;
      logic [2:0]  rs;
      logic [1:0]  ws;
      bit          mis;
      #3;
      got_p0 = p0_gnt; got_p1 = p1_gnt; got_wen = mem_wen;
      win = -1;
      if (m_force) begin
         if (p0_req) win = 0; else if (p1_req) win = 1;
      end else if (m_locked && p1_req && p1_lock) begin
         win = 1;
      end else if (p0_req && p1_req) begin
         win = 1 - m_last;
      end else if (p0_req) begin
         win = 0;
      end else if (p1_req) begin
         win = 1;
      end
      m_win = win;
      if (win == 0) begin
         we = p0_we; a = p0_addr; d = p0_wdata; rs = p0_rsel; ws = p0_wsel;
      end else if (win == 1) begin
         we = p1_we; a = p1_addr; d = p1_wdata; rs = p1_rsel; ws = p1_wsel;
      end else begin
         we = 1'b0; a = '0; d = '0; rs = '0; ws = '0;
      end
      mis = (win >= 0) && mis_model(we, rs, ws, a);
      if (chk_en) begin
         chk("p0_gnt", 32'(p0_gnt), 32'(win == 0));
         chk("p1_gnt", 32'(p1_gnt), 32'(win == 1));
         chk("mem_wen", 32'(mem_wen), 32'(we && !mis));
         chk("mem_addr", mem_addr, a);
         chk("mem_dataw", mem_dataw, d);
         chk("mem_rsel", 32'(mem_rsel), 32'(rs));
         chk("mem_wsel", 32'(mem_wsel), 32'(ws));
         chk("p0_rvalid", 32'(p0_rvalid), 32'(pv[0]));
         chk("p1_rvalid", 32'(p1_rvalid), 32'(pv[1]));
         if (pv[0]) chk("p0_err", 32'(p0_err), 32'(perr[0]));
         if (pv[1]) chk("p1_err", 32'(p1_err), 32'(perr[1]));
         if (pchk) chk("rdata", rdata, prdata);
      end
      // lock bookkeeping
      if (m_force) begin
         m_force = 0; m_locked = 0; m_run = 0;
      end else if (win == 1 && p1_lock) begin
         if (m_locked) m_run++;
         else begin m_locked = 1; m_run = 1; end
         if (m_run == MAX_LOCK) begin m_force = 1; m_locked = 0; m_run = 0; end
      end else begin
         m_locked = 0; m_run = 0;
      end
      if (win >= 0) m_last = win;
      // response for next cycle and memory effect
      pv = '0; perr = '0; pchk = 0;
      if (win >= 0) begin
         pv[win]   = !we || mis;
         perr[win] = mis;
         pchk      = !we && !mis;
         prdata    = ld_fmt(shadow[a[9:2]], a[1:0], rs);
         if (we && !mis) shadow[a[9:2]] = st_merge(shadow[a[9:2]], a[1:0], ws, d);
      end
      if (!rst_n) begin
         m_last = 1; m_locked = 0; m_run = 0; m_force = 0;
         pv = '0; perr = '0; pchk = 0;
      end
      @(posedge clk);
      #1;
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish, observed timeout expected $finish");
      $fatal(1);
   end

   initial begin
      int runs;
      for (int i = 0; i < 256; i++) shadow[i] = init_word(i);
      m_last = 1; m_run = 0; m_win = -1; m_locked = 0; m_force = 0;
      pv = '0; perr = '0; pchk = 0; prdata = '0;
      set_p0(0, 0, 0, 0, 0, 0);
      set_p1(0, 0, 0, 0, 0, 0, 0);

      // power-up reset
      rst_n = 0;
      tick(); tick();
      rst_n = 1; chk_en = 1;
      tick();
      chk("reset_p0_rvalid", 32'(p0_rvalid), 0);

      // T1: DMA preloads 0xDEADBEEF at 0x100, then CPU word load
      set_p1(1, 1, 32'h100, 32'hDEADBEEF, RSEL_W, WSEL_W, 0); tick();
      set_p1(0, 0, 0, 0, 0, 0, 0);
      set_p0(1, 0, 32'h100, 0, RSEL_W, WSEL_W); tick();
      chk("t1_gnt", 32'(got_p0), 1);
      set_p0(0, 0, 0, 0, 0, 0);
      chk("t1_rvalid", 32'(p0_rvalid), 1);
      chk("t1_rdata", rdata, 32'hDEADBEEF);
      tick();

      // T2: ties straight after reset alternate starting with port 0
      rst_n = 0; tick(); rst_n = 1;
      set_p0(1, 0, 32'h10, 0, RSEL_W, WSEL_W);
      set_p1(1, 0, 32'h20, 0, RSEL_W, WSEL_W, 0);
      for (int i = 0; i < 4; i++) begin
         tick();
         chk("t2_p0_gnt", 32'(got_p0), 32'(i % 2 == 0));
         chk("t2_p1_gnt", 32'(got_p1), 32'(i % 2 == 1));
      end
      set_p0(0, 0, 0, 0, 0, 0); set_p1(0, 0, 0, 0, 0, 0, 0); tick();

      // T3: byte store by port 1, then unsigned and signed byte loads
      set_p1(1, 1, 32'h203, 32'h000000AA, RSEL_W, WSEL_B, 0); tick();
      set_p1(0, 0, 0, 0, 0, 0, 0);
      set_p0(1, 0, 32'h203, 0, RSEL_BU, WSEL_W); tick();
      chk("t3_bu", rdata, 32'h000000AA);
      set_p0(1, 0, 32'h203, 0, RSEL_B, WSEL_W); tick();
      chk("t3_b", rdata, 32'hFFFFFFAA);
      set_p0(0, 0, 0, 0, 0, 0); tick();

      // T4: bounded lock, forced release to port 0, then relock
      set_p1(1, 0, 32'h300, 0, RSEL_W, WSEL_W, 1); tick();
      runs = got_p1 ? 1 : 0;
      set_p0(1, 0, 32'h304, 0, RSEL_W, WSEL_W);
      for (int i = 0; i < 40; i++) begin
         tick();
         if (got_p0) break;
         if (got_p1) runs++;
      end
      chk("t4_lock_run", 32'(runs), 16);
      tick();
      chk("t4_relock", 32'(got_p1), 1);
      set_p0(0, 0, 0, 0, 0, 0); set_p1(0, 0, 0, 0, 0, 0, 0); tick();

      // T5: misaligned half load and word store are answered with err
      set_p0(1, 0, 32'h101, 0, RSEL_H, WSEL_W); tick();
      chk("t5_ld_wen", 32'(got_wen), 0);
      set_p0(1, 1, 32'h102, 32'hFFFFFFFF, RSEL_W, WSEL_W);
      chk("t5_ld_rvalid", 32'(p0_rvalid), 1);
      chk("t5_ld_err", 32'(p0_err), 1);
      tick();
      chk("t5_st_wen", 32'(got_wen), 0);
      set_p0(1, 0, 32'h100, 0, RSEL_W, WSEL_W);
      chk("t5_st_rvalid", 32'(p0_rvalid), 1);
      chk("t5_st_err", 32'(p0_err), 1);
      tick();
      chk("t5_unchanged", rdata, 32'hDEADBEEF);
      set_p0(0, 0, 0, 0, 0, 0); tick();

      // T6: reset the cycle after a load grant; store in reset cycle still lands
      set_p0(1, 0, 32'h100, 0, RSEL_W, WSEL_W); tick();
      set_p0(0, 0, 0, 0, 0, 0);
      set_p1(1, 1, 32'h204, 32'h5A5A5A5A, RSEL_W, WSEL_W, 0);
      rst_n = 0; tick(); rst_n = 1;
      chk("t6_rvalid_dropped", 32'(p0_rvalid), 0);
      set_p0(1, 0, 32'h204, 0, RSEL_W, WSEL_W);
      set_p1(1, 0, 32'h208, 0, RSEL_W, WSEL_W, 0);
      tick();
      chk("t6_first_tie", 32'(got_p0), 1);
      set_p0(0, 0, 0, 0, 0, 0);
      chk("t6_store_landed", rdata, 32'h5A5A5A5A);
      tick();
      set_p1(0, 0, 0, 0, 0, 0, 0); tick();

      // Randomized traffic with alternating light and heavy lock phases
      for (int c = 0; c < 400; c++) begin
         bit heavy;
         heavy = ((c / 50) % 2) == 1;
         if (!p0_req || m_win == 0)
            set_p0(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 32'($urandom_range(0, 1023)),
                   $urandom, 3'($urandom_range(0, 4)), 2'($urandom_range(0, 2)));
         if (!p1_req || m_win == 1) begin
            set_p1(heavy ? 1'($urandom_range(0, 7) != 0) : 1'($urandom_range(0, 1)),
                   1'($urandom_range(0, 1)), 32'($urandom_range(0, 1023)), $urandom,
                   3'($urandom_range(0, 4)), 2'($urandom_range(0, 2)), p1_lock);
         end
         p1_lock = heavy ? 1'($urandom_range(0, 15) != 0) : 1'($urandom_range(0, 3) == 0);
         tick();
      end
      set_p0(0, 0, 0, 0, 0, 0); set_p1(0, 0, 0, 0, 0, 0, 0);
      tick(); tick();

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
